// File: rtl/bram_bist_if.sv
// Dual-port bram bus between the BIST initiator (master) and the bram (slave).
interface bram_bist_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic [DATA_W-1:0] data_a;
    logic [ADDR_W-1:0] addr_a;
    logic              we_a;
    logic [DATA_W-1:0] q_a;
    logic [DATA_W-1:0] data_b;
    logic [ADDR_W-1:0] addr_b;
    logic              we_b;
    logic [DATA_W-1:0] q_b;

    modport master (
        output data_a, addr_a, we_a,
        output data_b, addr_b, we_b,
        input  q_a, q_b
    );

    modport slave (
        input  data_a, addr_a, we_a,
        input  data_b, addr_b, we_b,
        output q_a, q_b
    );
endinterface

// File: rtl/bram_bist.sv
// Dual-port bram BIST: write A / read B, write ~B / read A, with error reporting.
// Define BRAM_BIST_STOP_ON_FAIL_EN to abort the test on the first mismatch.
module bram_bist #(
    parameter int                DATA_W = 16,
    parameter int                ADDR_W = 10,
    parameter int                DEPTH  = 1024,
    parameter logic [DATA_W-1:0] SEED   = 16'hA5C3,
    parameter int                ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] fail_addr,
    bram_bist_if.master       bram
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] WR_A = 3'd1;
    localparam logic [2:0] RD_B = 3'd2;
    localparam logic [2:0] DR_B = 3'd3;
    localparam logic [2:0] WR_B = 3'd4;
    localparam logic [2:0] RD_A = 3'd5;
    localparam logic [2:0] DR_A = 3'd6;
    localparam logic [2:0] DONE = 3'd7;

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX = '1;

    logic [2:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic              pipe_vld;
    logic              pipe_sel;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] pipe_exp;
    logic              any_err;

    logic [DATA_W-1:0] q_sel;
    logic              miss;
    logic              last;
    logic [ERR_W-1:0]  err_inc;
    logic [ADDR_W-1:0] cnt_nx;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) ^ SEED;
    endfunction

    // Read data lands one cycle after its address; the pipe holds what it should be.
    always_comb begin
        q_sel   = pipe_sel ? bram.q_a : bram.q_b;
        miss    = pipe_vld && (q_sel != pipe_exp);
        last    = (cnt == LAST);
        cnt_nx  = cnt + 1'b1;
        err_inc = (err_count == ERR_MAX) ? err_count : err_count + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            pipe_vld    <= 1'b0;
            pipe_sel    <= 1'b0;
            pipe_addr   <= '0;
            pipe_exp    <= '0;
            any_err     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            fail_addr   <= '0;
            bram.data_a <= '0;
            bram.addr_a <= '0;
            bram.we_a   <= 1'b0;
            bram.data_b <= '0;
            bram.addr_b <= '0;
            bram.we_b   <= 1'b0;
        end else begin
            pipe_vld <= 1'b0;
            if (miss) begin
                err_count <= err_inc;
                any_err   <= 1'b1;
                if (!any_err) begin
                    fail_addr <= pipe_addr;
                end
            end
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= WR_A;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        err_count   <= '0;
                        fail_addr   <= '0;
                        any_err     <= 1'b0;
                        cnt         <= '0;
                        bram.we_a   <= 1'b1;
                        bram.addr_a <= '0;
                        bram.data_a <= pat('0);
                    end
                end
                WR_A: begin
                    if (last) begin
                        state       <= RD_B;
                        cnt         <= '0;
                        bram.we_a   <= 1'b0;
                        bram.addr_b <= '0;
                    end else begin
                        cnt         <= cnt_nx;
                        bram.addr_a <= cnt_nx;
                        bram.data_a <= pat(cnt_nx);
                    end
                end
                RD_B: begin
                    pipe_vld  <= 1'b1;
                    pipe_sel  <= 1'b0;
                    pipe_addr <= cnt;
                    pipe_exp  <= pat(cnt);
                    if (last) begin
                        state <= DR_B;
                    end else begin
                        cnt         <= cnt_nx;
                        bram.addr_b <= cnt_nx;
                    end
                end
                DR_B: begin
                    state       <= WR_B;
                    cnt         <= '0;
                    bram.we_b   <= 1'b1;
                    bram.addr_b <= '0;
                    bram.data_b <= ~pat('0);
                end
                WR_B: begin
                    if (last) begin
                        state       <= RD_A;
                        cnt         <= '0;
                        bram.we_b   <= 1'b0;
                        bram.addr_a <= '0;
                    end else begin
                        cnt         <= cnt_nx;
                        bram.addr_b <= cnt_nx;
                        bram.data_b <= ~pat(cnt_nx);
                    end
                end
                RD_A: begin
                    pipe_vld  <= 1'b1;
                    pipe_sel  <= 1'b1;
                    pipe_addr <= cnt;
                    pipe_exp  <= ~pat(cnt);
                    if (last) begin
                        state <= DR_A;
                    end else begin
                        cnt         <= cnt_nx;
                        bram.addr_a <= cnt_nx;
                    end
                end
                DR_A: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= !(any_err || miss);
                end
                default: state <= IDLE;
            endcase
`ifdef BRAM_BIST_STOP_ON_FAIL_EN
            // First mismatch overrides whatever the phase wanted to do next.
            if (miss) begin
                state     <= DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
                pass      <= 1'b0;
                pipe_vld  <= 1'b0;
                bram.we_a <= 1'b0;
                bram.we_b <= 1'b0;
            end
`else
`endif
        end
    end

endmodule

// File: tb/tb_bram_bist.sv
// Bench for bram_bist: three depths, faulty-bram models, behavioural expectations.
module tb_bram_bist;

    localparam int          NI   = 3;
    localparam logic [15:0] SEED = 16'hA5C3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] start_v;
    logic [NI-1:0] busy_v;
    logic [NI-1:0] done_v;
    logic [NI-1:0] pass_v;
    logic [NI-1:0] wea_v;
    logic [NI-1:0] web_v;
    logic [7:0]    err_v [NI];
    logic [9:0]    fa_v  [NI];
    logic [51:0]   bus_v [NI];

    int          f_mode = 0;
    int          f_addr = 0;
    int          f_bit  = 0;
    logic [15:0] f_mask = 16'h0;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic int depth_of(input int g);
        return (g == 0) ? 32 : ((g == 1) ? 256 : 1);
    endfunction

    function automatic logic [15:0] pat(input int i);
        return 16'(i) ^ SEED;
    endfunction

    // Fault model of the bram read path: 1 = port-B bit stuck-at-1,
    // 2 = one address corrupted on both ports, 3 = every read wrong.
    function automatic logic [15:0] flt(input bit portb, input int a, input logic [15:0] v);
        logic [15:0] r;
        r = v;
        case (f_mode)
            1: if (portb) r[f_bit] = 1'b1;
            2: if (a == f_addr) r = r ^ f_mask;
            3: r = r ^ 16'h0001;
            default: ;
        endcase
        return r;
    endfunction

    generate
        for (genvar g = 0; g < NI; g++) begin : gd
            localparam int D = (g == 0) ? 32 : ((g == 1) ? 256 : 1);
            bram_bist_if #(.DATA_W(16), .ADDR_W(10)) bus ();
            logic [15:0] mem [0:1023];

            bram_bist #(
                .DATA_W(16), .ADDR_W(10), .DEPTH(D), .SEED(SEED), .ERR_W(8)
            ) dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .start     (start_v[g]),
                .busy      (busy_v[g]),
                .done      (done_v[g]),
                .pass      (pass_v[g]),
                .err_count (err_v[g]),
                .fail_addr (fa_v[g]),
                .bram      (bus.master)
            );

            always @(posedge clk) begin
                if (bus.we_a) mem[bus.addr_a] <= bus.data_a;
                if (bus.we_b) mem[bus.addr_b] <= bus.data_b;
                bus.q_a <= flt(1'b0, int'(bus.addr_a), mem[bus.addr_a]);
                bus.q_b <= flt(1'b1, int'(bus.addr_b), mem[bus.addr_b]);
            end

            assign wea_v[g] = bus.we_a;
            assign web_v[g] = bus.we_b;
            assign bus_v[g] = {bus.addr_a, bus.addr_b, bus.data_a, bus.data_b};
        end
    endgenerate

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Expected outcome from the read-back rules: which compares miss, and when.
    task automatic model(input int d, output int busy_c, output int err,
                         output int fa, output int ps);
        int n, first, fc;
        logic [15:0] e;
        n = 0; first = -1; fc = 0;
        for (int i = 0; i < d; i++) begin
            e = pat(i);
            if (flt(1'b1, i, e) != e) begin
                if (first < 0) begin first = i; fc = d + 2 + i; end
                n++;
            end
        end
        for (int i = 0; i < d; i++) begin
            e = ~pat(i);
            if (flt(1'b0, i, e) != e) begin
                if (first < 0) begin first = i; fc = 3 * d + 3 + i; end
                n++;
            end
        end
        busy_c = 4 * d + 2;
        err    = (n > 255) ? 255 : n;
`ifdef BRAM_BIST_STOP_ON_FAIL_EN
        if (n > 0) begin busy_c = fc; err = 1; end
`else
`endif
        fa = (first < 0) ? 0 : first;
        ps = (n == 0) ? 1 : 0;
    endtask

    task automatic run_test(input int g, input bit hold, input string tag);
        int d, eb, ee, ef, ep, cyc;
        bit both;
        d = depth_of(g);
        model(d, eb, ee, ef, ep);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        start_v[g] = 1'b1;
        @(negedge clk);
        if (!hold) start_v[g] = 1'b0;
        check({tag, " busy_rise"}, 64'(busy_v[g]), 64'(1));
        check({tag, " clr"}, 64'({done_v[g], pass_v[g], err_v[g], fa_v[g]}), 64'(0));
        cyc = 0; both = 1'b0;
        while (busy_v[g] && cyc < 10000) begin
            cyc++;
            if (wea_v[g] && web_v[g]) both = 1'b1;
            @(negedge clk);
        end
        start_v[g] = 1'b0;
        check({tag, " busy_len"}, 64'(cyc), 64'(eb));
        check({tag, " done"}, 64'(done_v[g]), 64'(1));
        check({tag, " pass"}, 64'(pass_v[g]), 64'(ep));
        check({tag, " err"}, 64'(err_v[g]), 64'(ee));
        check({tag, " fail_addr"}, 64'(fa_v[g]), 64'(ef));
        check({tag, " dual_we"}, 64'(both), 64'(0));
        repeat (2) @(negedge clk);
        check({tag, " hold_done"}, 64'({busy_v[g], done_v[g]}), 64'(1));
    endtask

    initial begin
        start_v = '0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("rst_out%0d", g),
                  64'({busy_v[g], done_v[g], pass_v[g], err_v[g], fa_v[g],
                       wea_v[g], web_v[g]}), 64'(0));
            check($sformatf("rst_bus%0d", g), 64'(bus_v[g]), 64'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);

        f_mode = 0;
        run_test(0, 1'b0, "clean32");
        check("mem5", 64'(gd[0].mem[5]), 64'(16'h5A39));

        f_mode = 1; f_bit = 3;
        run_test(0, 1'b0, "stuckb3");

        f_mode = 2; f_addr = 7; f_mask = 16'h0100;
        run_test(0, 1'b1, "addr7_hold");

        for (int k = 0; k < 4; k++) begin
            f_mode = int'($urandom_range(0, 2));
            f_addr = int'($urandom_range(0, 31));
            f_bit  = int'($urandom_range(0, 15));
            f_mask = 16'($urandom_range(1, 65535));
            run_test(0, 1'($urandom_range(0, 1)), $sformatf("rand%0d", k));
        end

        f_mode = 0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (70) @(negedge clk);
        check("mid_web", 64'(web_v[0]), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_web", 64'({web_v[0], wea_v[0]}), 64'(0));
        check("rst_out", 64'({busy_v[0], done_v[0], pass_v[0], err_v[0], fa_v[0]}), 64'(0));
        check("rst_bus", 64'(bus_v[0]), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_idle", 64'({busy_v[0], done_v[0]}), 64'(0));
        run_test(0, 1'b0, "after_rst");

        f_mode = 3;
        run_test(1, 1'b0, "sat256");

        f_mode = 0;
        run_test(2, 1'b0, "depth1");
        f_mode = 1; f_bit = 3;
        run_test(2, 1'b0, "depth1_bad");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bram_bist.md
Name: bram_bist

Overview:
- Built-in self-test initiator for the dual-port 16x1024 bram. It drives both bram ports and checks the read data it gets back.
- On start it runs four phases:
  - write a pattern through port A, then read it back and check it through port B;
  - write the inverted pattern through port B, then read it back and check it through port A.
- It reports pass/fail, an error count and the first failing address.
- It sits between the top-level control and the bram instance, in place of the bench-driven stimulus.

Parameters:
- DATA_W, 16, bram word width.
- ADDR_W, 10, bram address width.
- DEPTH, 1024, number of words tested, addresses 0..DEPTH-1. Legal range 1..2^ADDR_W.
- SEED, 16'hA5C3, XOR seed for the test pattern.
- ERR_W, 8, error counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; sampled only in IDLE.
- busy  out  1  high while a test runs.
- done  out  1  high from test end until the next accepted start.
- pass  out  1  valid while done=1; 1 = zero mismatches.
- err_count  out  ERR_W  mismatch count; saturating.
- fail_addr  out  ADDR_W  address of the first mismatch; 0 if none.
- data_a  out  DATA_W  bram port A write data.
- addr_a  out  ADDR_W  bram port A address.
- we_a  out  1  bram port A write enable.
- q_a  in  DATA_W  bram port A read data.
- data_b  out  DATA_W  bram port B write data.
- addr_b  out  ADDR_W  bram port B address.
- we_b  out  1  bram port B write enable.
- q_b  in  DATA_W  bram port B read data.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values (on rst_n=0, all outputs zero):
  - busy, done, pass, err_count, fail_addr, we_a, we_b = 0;
  - addr_a, addr_b, data_a, data_b = 0.
- Reset asserted mid-test:
  - we_a and we_b drop immediately, without waiting for a clock;
  - the FSM returns to IDLE and the results are cleared.
- All outputs are registered.
- Pattern:
  - P(i) = i zero-extended to DATA_W, XOR SEED;
  - N(i) = bitwise NOT of P(i).
- bram read model: synchronous read. q_x reflects the address presented at edge k on edge k+1.
- FSM states, in order: IDLE, WR_A, RD_B, DR_B, WR_B, RD_A, DR_A, DONE.
  - IDLE: start=1 moves to WR_A.
    - Clears err_count, fail_addr, done and pass.
    - Sets busy=1.
  - WR_A: we_a=1, addr_a=i, data_a=P(i), for i=0..DEPTH-1, one word per cycle.
  - RD_B: we_b=0, addr_b=i, for i=0..DEPTH-1.
    - q_b is compared against P of the address issued one cycle earlier.
    - The expected value and address travel in a 1-stage pipeline register.
  - DR_B: one drain cycle that compares the last read.
  - WR_B: we_b=1, addr_b=i, data_b=N(i), for i=0..DEPTH-1.
  - RD_A: we_a=0, addr_a=i, for i=0..DEPTH-1; q_a is compared against N(addr).
  - DR_A: one drain cycle that compares the last read.
  - DONE: busy=0, done=1, pass=(err_count==0).
    - The state is held while start=0.
    - start=1 in DONE begins a new test exactly as from IDLE.
- Timing:
  - busy is high for exactly 4*DEPTH+2 cycles;
  - done rises on the same edge that busy falls.
- Enables: we_a/we_b are high only in WR_A/WR_B respectively. No cycle ever has both ports writing.
- Boundary rules:
  - Address wrap: the address counter stops at DEPTH-1 and never wraps within a phase. It resets to 0 at each phase entry.
  - Mismatch counting: each mismatch increments err_count, which saturates at 2^ERR_W-1.
  - fail_addr latches only on the first mismatch of a test.
  - start while busy is ignored.
  - DEPTH=1 is legal: busy lasts 6 cycles.

Optional Feature:
- Macro: BRAM_BIST_STOP_ON_FAIL_EN.
- When defined, the first mismatch aborts the test:
  - the FSM goes straight to DONE on the edge after the compare;
  - we_a and we_b are forced to 0;
  - err_count=1, pass=0.
- When not defined, all four phases always run to completion and every mismatch is counted.

Test Plan:
- DEPTH=32, fault-free bram, start pulsed 1 cycle -> busy high 130 cycles, done=1, pass=1, err_count=0, fail_addr=0. Final bram contents: word 5 = ~(16'h0005^16'hA5C3) = 16'h5A39.
- bram model with bit 3 of port-B read data stuck-at-1, DEPTH=32 -> 16 mismatches in RD_B:
  - err_count=16, pass=0;
  - fail_addr is the lowest failing address;
  - RD_A compares are clean.
- bram model corrupting address 7 only, DEPTH=32 -> fail_addr=7, pass=0.
  - With BRAM_BIST_STOP_ON_FAIL_EN defined: done asserted the edge after address 7 is compared, err_count=1, no further writes.
- rst_n pulled low during WR_B -> we_b=0 before the next clk edge, all outputs 0, FSM in IDLE. A new start afterwards runs a full 130-cycle pass.
- start held high throughout a run, and start re-pulsed in DONE -> no restart while busy. Restart from DONE clears done/pass/err_count on the accept edge.
- Saturation: force every read to mismatch, DEPTH=256 -> err_count=255, not wrapped; pass=0.
